// File: rtl/mem_stage_wide.sv
// MEM pipeline stage: splits RV32I loads/stores into BUS_BYTES-wide ready-handshaked beats,
// assembles and extends load data, and stalls the pipeline until the access completes.
module mem_stage_wide #(
  parameter int BUS_BYTES = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             opcode_i,
  input  logic [2:0]             funct3_i,
  input  logic [4:0]             wd_i,
  input  logic                   wreg_i,
  input  logic [31:0]            wdata_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic                   mem_ready_i,
  input  logic [8*BUS_BYTES-1:0] mem_data_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [BUS_BYTES-1:0]   mem_be_o,
  output logic [8*BUS_BYTES-1:0] mem_data_o,
  output logic                   stall_req_o,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [31:0]            wdata_o
);

  localparam int BW = 8 * BUS_BYTES;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t         state_q;
  logic [1:0]     beat_q, last_q;
  logic [2:0]     size_q;
  logic           sign_q, we_q, done_q;
  logic [31:0]    sdata_q, asm_q;

  logic           is_load, is_store, is_mem;
  logic [2:0]     size_d;
  logic [1:0]     last_d, next_beat;
  logic [BUS_BYTES-1:0] be_d;
  logic [31:0]    rdata32, sdata_next, load_res;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    is_load  = (opcode_i == OP_LOAD) && (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    is_store = (opcode_i == OP_STORE) && (funct3_i inside {3'd0, 3'd1, 3'd2});
    is_mem   = is_load || is_store;
    case (funct3_i[1:0])
      2'd0:    size_d = 3'd1;
      2'd1:    size_d = 3'd2;
      default: size_d = 3'd4;
    endcase
    last_d = '0;
    if (int'(size_d) > BUS_BYTES) last_d = 2'(int'(size_d) / BUS_BYTES - 1);
    be_d = '0;
    for (int i = 0; i < BUS_BYTES; i++) be_d[i] = (i < int'(size_d));
  end

  assign rdata32    = 32'(mem_data_i);
  assign next_beat  = beat_q + 2'd1;
  assign sdata_next = sdata_q >> (BW * int'(next_beat));

  always_comb begin
    case (size_q)
      3'd1:    load_res = sign_q ? {{24{asm_q[7]}}, asm_q[7:0]}   : {24'd0, asm_q[7:0]};
      3'd2:    load_res = sign_q ? {{16{asm_q[15]}}, asm_q[15:0]} : {16'd0, asm_q[15:0]};
      default: load_res = asm_q;
    endcase
  end

  // The done flag keeps a finished op from restarting while it is still sitting in MEM.
  assign stall_req_o = !rst && is_mem && (state_q != DONE) && !done_q;
  assign wd_o        = rst ? 5'd0 : wd_i;
  assign wreg_o      = rst ? 1'b0 : wreg_i;
  assign wdata_o     = rst ? 32'd0 : ((state_q == DONE) && !we_q) ? load_res : wdata_i;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      sdata_q    <= '0;
      asm_q      <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_be_o   <= '0;
      mem_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem && !done_q) begin
            size_q     <= size_d;
            sign_q     <= !funct3_i[2];
            we_q       <= is_store;
            last_q     <= last_d;
            beat_q     <= '0;
            sdata_q    <= wdata_i;
            asm_q      <= '0;
            mem_req_o  <= 1'b1;
            mem_we_o   <= is_store;
            mem_addr_o <= mem_addr_i;
            mem_be_o   <= be_d;
            mem_data_o <= wdata_i[BW-1:0];
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (mem_ready_i) begin
            if (!we_q) asm_q <= asm_q | (rdata32 << (BW * int'(beat_q)));
            if (beat_q == last_q) begin
              mem_req_o <= 1'b0;
              mem_we_o  <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              beat_q     <= next_beat;
              mem_addr_o <= mem_addr_o + ADDR_W'(BUS_BYTES);
              mem_data_o <= sdata_next[BW-1:0];
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_wide.sv
// Self-checking bench: three instances (BUS_BYTES 1/2/4) against a byte-array memory and
// a reference model computing load values, beat counts and stall lengths from the access rules.
module tb_mem_stage_wide;

  logic clk;
  logic rst;

  logic [6:0]  opcode [3];
  logic [2:0]  funct3 [3];
  logic [4:0]  wd     [3];
  logic        wreg   [3];
  logic [31:0] wdata  [3];
  logic [31:0] addr   [3];
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic        req    [3];
  logic        we     [3];
  logic [31:0] maddr  [3];
  logic [3:0]  be     [3];
  logic [31:0] mdata  [3];
  logic        stall  [3];
  logic [4:0]  wdo    [3];
  logic        wrego  [3];
  logic [31:0] wdatao [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BB = 1 << g;
    logic          req_w, we_w, stall_w, wreg_w;
    logic [31:0]   addr_w, wdata_w;
    logic [BB-1:0] be_w;
    logic [8*BB-1:0] md_w;
    logic [4:0]    wd_w;
    mem_stage_wide #(.BUS_BYTES(BB), .ADDR_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .opcode_i(opcode[g]), .funct3_i(funct3[g]), .wd_i(wd[g]), .wreg_i(wreg[g]),
      .wdata_i(wdata[g]), .mem_addr_i(addr[g]), .mem_ready_i(ready[g]),
      .mem_data_i(rdata[g][8*BB-1:0]),
      .mem_req_o(req_w), .mem_we_o(we_w), .mem_addr_o(addr_w), .mem_be_o(be_w),
      .mem_data_o(md_w), .stall_req_o(stall_w), .wd_o(wd_w), .wreg_o(wreg_w),
      .wdata_o(wdata_w)
    );
    assign req[g]    = req_w;
    assign we[g]     = we_w;
    assign maddr[g]  = addr_w;
    assign be[g]     = 4'(be_w);
    assign mdata[g]  = 32'(md_w);
    assign stall[g]  = stall_w;
    assign wdo[g]    = wd_w;
    assign wrego[g]  = wreg_w;
    assign wdatao[g] = wdata_w;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int hold_beat = -1;
  int hold_len = 0;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;

  function automatic int mi(input logic [31:0] x);
    return int'(x[9:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs(input int g);
    opcode[g] = OPIMM; funct3[g] = 3'd0; wd[g] = 5'd0; wreg[g] = 1'b0;
    wdata[g] = 32'd0; addr[g] = 32'd0; ready[g] = 1'b0; rdata[g] = 32'd0;
  endtask

  // Called at a falling edge; returns at the falling edge after the op has left MEM.
  task automatic run_op(input int g, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wv,
                        output logic [31:0] res, output int sc, output int waits);
    int bb, s, n, beats, held, lanes;
    bit ld, st, mem_op, finished, prev_wait, r;
    logic [31:0] exp_w, val, p_addr, p_data;
    logic [3:0]  p_be;
    logic        p_we;
    logic [4:0]  rd;
    logic [7:0]  after_byte;
    bb     = 1 << g;
    ld     = (op == LOAD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st     = (op == STORE) && (f3 <= 3'd2);
    mem_op = ld || st;
    s      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    n      = mem_op ? ((s > bb) ? s / bb : 1) : 0;
    lanes  = (s < bb) ? s : bb;
    val = 32'd0;
    for (int i = 0; i < s; i++) val = val | (32'(mem[mi(a + 32'(i))]) << (8 * i));
    exp_w = wv;
    if (ld) begin
      exp_w = val;
      if (!f3[2] && s < 4 && val[8*s-1]) exp_w = val - (32'd1 << (8 * s));
    end
    after_byte = mem[mi(a + 32'(s))];
    rd = 5'($urandom);
    opcode[g] = op; funct3[g] = f3; addr[g] = a; wdata[g] = wv; wd[g] = rd; wreg[g] = 1'b1;
    beats = 0; sc = 0; waits = 0; held = 0; prev_wait = 0; finished = 0;
    p_addr = '0; p_data = '0; p_be = '0; p_we = 1'b0; res = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (cyc == 0) begin
        check("wd_pass", 32'(wdo[g]), 32'(rd));
        check("wreg_pass", 32'(wrego[g]), 32'd1);
      end
      if (prev_wait) begin
        check("hold_addr", maddr[g], p_addr);
        check("hold_data", mdata[g], p_data);
        check("hold_be", 32'(be[g]), 32'(p_be));
        check("hold_we", 32'(we[g]), 32'(p_we));
      end
      prev_wait = 0;
      if (req[g]) begin
        check("beat_addr", maddr[g], a + 32'(beats * bb));
        check("beat_be", 32'(be[g]), (32'd1 << lanes) - 32'd1);
        check("beat_we", 32'(we[g]), 32'(st));
        if (st)
          for (int l = 0; l < lanes; l++)
            check("store_lane", 32'(mdata[g][8*l +: 8]), 32'(wv[8*(beats*bb + l) +: 8]));
        if (beats == hold_beat && held < hold_len) begin
          r = 0; held++;
        end else begin
          r = ($urandom_range(0, 99) < rdy_pct);
        end
        ready[g] = r;
        rdata[g] = $urandom;
        for (int l = 0; l < bb; l++) rdata[g][8*l +: 8] = mem[mi(maddr[g] + 32'(l))];
        if (r) begin
          if (we[g])
            for (int l = 0; l < bb; l++)
              if (be[g][l]) mem[mi(maddr[g] + 32'(l))] = mdata[g][8*l +: 8];
          beats++;
        end else begin
          waits++;
          prev_wait = 1;
          p_addr = maddr[g]; p_data = mdata[g]; p_be = be[g]; p_we = we[g];
        end
      end else begin
        ready[g] = 1'($urandom_range(0, 1));
        rdata[g] = $urandom;
      end
      if (!stall[g]) begin
        finished = 1;
        res = wdatao[g];
        break;
      end
      sc++;
      @(negedge clk);
    end
    check("op_finished", 32'(finished), 32'd1);
    check("beat_count", 32'(beats), 32'(n));
    check("stall_cycles", 32'(sc), mem_op ? 32'(n + 1 + waits) : 32'd0);
    check("wdata_out", res, exp_w);
    if (st) begin
      for (int i = 0; i < s; i++) check("store_mem", 32'(mem[mi(a + 32'(i))]), 32'(wv[8*i +: 8]));
      check("store_bound", 32'(mem[mi(a + 32'(s))]), 32'(after_byte));
    end
    @(negedge clk);
    idle_inputs(g);
  endtask

  typedef struct {
    int          g;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wv;
    logic [31:0] exp_w;
    int          exp_stall;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] res;
    int sc, waits;
    bit found;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h104] = 8'h9A; mem[32'h010] = 8'h80; mem[32'h011] = 8'h00;

    // Reset with a memory op presented: everything must read zero.
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      idle_inputs(g);
      opcode[g] = LOAD; funct3[g] = 3'd2; wd[g] = 5'd17; wreg[g] = 1'b1;
      wdata[g] = 32'hA5A5_5A5A; addr[g] = 32'h100; ready[g] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_req", 32'(req[g]), 32'd0);
      check("rst_we", 32'(we[g]), 32'd0);
      check("rst_addr", maddr[g], 32'd0);
      check("rst_be", 32'(be[g]), 32'd0);
      check("rst_data", mdata[g], 32'd0);
      check("rst_stall", 32'(stall[g]), 32'd0);
      check("rst_wdata", wdatao[g], 32'd0);
      check("rst_wd", 32'(wdo[g]), 32'd0);
      check("rst_wreg", 32'(wrego[g]), 32'd0);
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) idle_inputs(g);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with ready tied high.
    vecs[0]  = '{0, LOAD,  3'd2, 32'h100, 32'h0,         32'h44332211, 5};
    vecs[1]  = '{2, STORE, 3'd1, 32'h203, 32'hDEADBEEF,  32'hDEADBEEF, 2};
    vecs[2]  = '{1, LOAD,  3'd0, 32'h010, 32'h0,         32'hFFFFFF80, 2};
    vecs[3]  = '{1, LOAD,  3'd4, 32'h010, 32'h0,         32'h00000080, 2};
    vecs[4]  = '{0, OPIMM, 3'd0, 32'h000, 32'h7,         32'h00000007, 0};
    vecs[5]  = '{0, LOAD,  3'd1, 32'h102, 32'h0,         32'h00004433, 3};
    vecs[6]  = '{2, LOAD,  3'd2, 32'h101, 32'h0,         32'h9A443322, 2};
    vecs[7]  = '{1, LOAD,  3'd5, 32'h103, 32'h0,         32'h00009A44, 2};
    vecs[8]  = '{1, LOAD,  3'd1, 32'h103, 32'h0,         32'hFFFF9A44, 2};
    vecs[9]  = '{2, LOAD,  3'd0, 32'h104, 32'h0,         32'hFFFFFF9A, 2};
    vecs[10] = '{0, LOAD,  3'd3, 32'h100, 32'h1234,      32'h00001234, 0};
    vecs[11] = '{1, STORE, 3'd4, 32'h100, 32'h5678,      32'h00005678, 0};
    vecs[12] = '{1, LOAD,  3'd2, 32'h100, 32'h0,         32'h44332211, 3};
    rdy_pct = 100;
    for (int v = 0; v < 13; v++) begin
      run_op(vecs[v].g, vecs[v].op, vecs[v].f3, vecs[v].a, vecs[v].wv, res, sc, waits);
      check($sformatf("vec%0d_wdata", v), res, vecs[v].exp_w);
      check($sformatf("vec%0d_stall", v), 32'(sc), 32'(vecs[v].exp_stall));
    end

    // SW on the byte bus with ready low for three cycles on beat 1.
    hold_beat = 1; hold_len = 3;
    run_op(0, STORE, 3'd2, 32'h300, 32'hCAFEF00D, res, sc, waits);
    check("sw_hold_stall", 32'(sc), 32'd8);
    check("sw_hold_waits", 32'(waits), 32'd3);
    hold_beat = -1; hold_len = 0;

    // Reset during beat 2 of an LW, then a fresh LW.
    opcode[0] = LOAD; funct3[0] = 3'd2; addr[0] = 32'h100; ready[0] = 1'b1; wreg[0] = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (req[0] && maddr[0] == 32'h102) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_found", 32'(found), 32'd1);
    rst = 1'b1;
    opcode[0] = OPIMM; wd[0] = 5'd9;
    #1;
    check("rst_mid_stall", 32'(stall[0]), 32'd0);
    check("rst_mid_wdata", wdatao[0], 32'd0);
    check("rst_mid_wd", 32'(wdo[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after_req", 32'(req[0]), 32'd0);
    check("rst_after_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    idle_inputs(0);
    run_op(0, LOAD, 3'd2, 32'h100, 32'h0, res, sc, waits);
    check("lw_after_rst", res, 32'h44332211);

    // Randomized mix with random ready on every bus width.
    rdy_pct = 60;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 60; k++) begin
        int sel;
        logic [6:0] op;
        sel = $urandom_range(0, 4);
        op = (sel < 2) ? LOAD : (sel < 4) ? STORE : OPIMM;
        run_op(g, op, 3'($urandom), 32'($urandom_range(0, 1023)), $urandom, res, sc, waits);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
